// File: rtl/iic_pkg.sv
// Shared I2C definitions: FSM state encoding and ACK/NACK bus levels.
package iic_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_DEV_ADDR  = 4'd1,
        ST_DEV_ACK   = 4'd2,
        ST_WORD_ADDR = 4'd3,
        ST_WORD_ACK  = 4'd4,
        ST_WR_DATA   = 4'd5,
        ST_WR_ACK    = 4'd6,
        ST_RD_DATA   = 4'd7,
        ST_RD_ACK    = 4'd8,
        ST_WAIT_STOP = 4'd9
    } iic_state_e;

    localparam logic       IIC_ACK   = 1'b0;
    localparam logic       IIC_NACK  = 1'b1;
    localparam logic [3:0] BYTE_BITS = 4'd8;

    // Address byte is {addr[6:0], r/w}; only the upper seven bits identify the slave.
    function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] dev);
        return (addr_byte[7:1] == dev);
    endfunction

endpackage

// File: rtl/iic_bit_sync.sv
// Synchronizes scl/sda into the i_clk domain and flags scl edges plus START/STOP.
module iic_bit_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_smp
);

    logic [SYNC_STAGES-1:0] scl_sync_r;
    logic [SYNC_STAGES-1:0] sda_sync_r;
    logic                   scl_prev_r;
    logic                   sda_prev_r;
    logic                   scl_now_s;
    logic                   sda_now_s;

    assign scl_now_s = scl_sync_r[SYNC_STAGES-1];
    assign sda_now_s = sda_sync_r[SYNC_STAGES-1];

    // Synchronizer chains plus one extra sample for edge comparison; idle bus reads high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_r <= '1;
            sda_sync_r <= '1;
            scl_prev_r <= 1'b1;
            sda_prev_r <= 1'b1;
        end else begin
            scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl_in};
            sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda_in};
            scl_prev_r <= scl_now_s;
            sda_prev_r <= sda_now_s;
        end
    end

    assign scl_rise  = scl_now_s & ~scl_prev_r;
    assign scl_fall  = ~scl_now_s & scl_prev_r;
    // sda may only move while scl is low; a change with scl held high is framing.
    assign start_det = scl_now_s & scl_prev_r & sda_prev_r & ~sda_now_s;
    assign stop_det  = scl_now_s & scl_prev_r & ~sda_prev_r & sda_now_s;
    assign sda_smp   = sda_now_s;

endmodule

// File: rtl/iic_slave_resp.sv
// I2C slave front end for an 8-bit register file: word-pointer write, sequential
// writes and reads with pointer auto-increment, open-drain sda.
module iic_slave_resp
    import iic_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [6:0] i_dev_addr,
    input  logic       scl,
    inout  wire        sda,
    output logic [7:0] o_reg_addr,
    output logic [7:0] o_reg_wdata,
    output logic       o_reg_we,
    input  logic [7:0] i_reg_rdata,
    output logic       o_busy,
    output logic [3:0] o_state
);

    iic_state_e state_r;
    logic [3:0] bit_cnt_r;
    logic [7:0] shift_r;
    logic       rw_r;
    logic       sda_low_r;

    logic       scl_rise_s;
    logic       scl_fall_s;
    logic       start_s;
    logic       stop_s;
    logic       sda_smp_s;
    logic [7:0] rx_byte_s;

    iic_bit_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_bit_sync (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .scl_in   (scl),
        .sda_in   (sda),
        .scl_rise (scl_rise_s),
        .scl_fall (scl_fall_s),
        .start_det(start_s),
        .stop_det (stop_s),
        .sda_smp  (sda_smp_s)
    );

    assign rx_byte_s = {shift_r[6:0], sda_smp_s};
    assign sda       = sda_low_r ? 1'b0 : 1'bz;
    assign o_state   = state_r;

    // Protocol FSM: framing first, then per-state bit handling on scl edges.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= 4'd0;
            shift_r     <= 8'h00;
            rw_r        <= 1'b0;
            sda_low_r   <= 1'b0;
            o_reg_addr  <= 8'h00;
            o_reg_wdata <= 8'h00;
            o_reg_we    <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            o_reg_we <= 1'b0;
            // Pointer advances the cycle after the write strobe, so the strobe sees the old address.
            if (o_reg_we) begin
                o_reg_addr <= o_reg_addr + 8'd1;
            end

            if (stop_s) begin
                state_r   <= ST_IDLE;
                bit_cnt_r <= 4'd0;
                sda_low_r <= 1'b0;
                o_busy    <= 1'b0;
            end else if (start_s) begin
                state_r   <= ST_DEV_ADDR;
                bit_cnt_r <= 4'd0;
                sda_low_r <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE, ST_WAIT_STOP: begin
                        sda_low_r <= 1'b0;
                    end

                    ST_DEV_ADDR, ST_WORD_ADDR, ST_WR_DATA: begin
                        if (scl_rise_s && (bit_cnt_r < BYTE_BITS)) begin
                            shift_r   <= rx_byte_s;
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                            if (bit_cnt_r == (BYTE_BITS - 4'd1)) begin
                                if (state_r == ST_WORD_ADDR) begin
                                    o_reg_addr <= rx_byte_s;
                                end else if (state_r == ST_WR_DATA) begin
                                    o_reg_wdata <= rx_byte_s;
                                    o_reg_we    <= 1'b1;
                                end else begin
                                    o_reg_we <= 1'b0;
                                end
                            end
                        end else if (scl_fall_s && (bit_cnt_r == BYTE_BITS)) begin
                            bit_cnt_r <= 4'd0;
                            if (state_r == ST_DEV_ADDR) begin
                                if (addr_match(shift_r, i_dev_addr)) begin
                                    state_r   <= ST_DEV_ACK;
                                    sda_low_r <= 1'b1;
                                    o_busy    <= 1'b1;
                                    rw_r      <= shift_r[0];
                                end else begin
                                    state_r   <= ST_WAIT_STOP;
                                    sda_low_r <= 1'b0;
                                    o_busy    <= 1'b0;
                                end
                            end else if (state_r == ST_WORD_ADDR) begin
                                state_r   <= ST_WORD_ACK;
                                sda_low_r <= 1'b1;
                            end else begin
                                state_r   <= ST_WR_ACK;
                                sda_low_r <= 1'b1;
                            end
                        end
                    end

                    ST_DEV_ACK: begin
                        if (scl_fall_s) begin
                            bit_cnt_r <= 4'd0;
                            if (rw_r) begin
                                state_r   <= ST_RD_DATA;
                                shift_r   <= i_reg_rdata;
                                sda_low_r <= ~i_reg_rdata[7];
                            end else begin
                                state_r   <= ST_WORD_ADDR;
                                sda_low_r <= 1'b0;
                            end
                        end
                    end

                    ST_WORD_ACK, ST_WR_ACK: begin
                        if (scl_fall_s) begin
                            state_r   <= ST_WR_DATA;
                            bit_cnt_r <= 4'd0;
                            sda_low_r <= 1'b0;
                        end
                    end

                    ST_RD_DATA: begin
                        if (scl_fall_s) begin
                            if (bit_cnt_r < (BYTE_BITS - 4'd1)) begin
                                shift_r   <= {shift_r[6:0], 1'b0};
                                sda_low_r <= ~shift_r[6];
                                bit_cnt_r <= bit_cnt_r + 4'd1;
                            end else begin
                                state_r   <= ST_RD_ACK;
                                sda_low_r <= 1'b0;
                                bit_cnt_r <= 4'd0;
                            end
                        end
                    end

                    // bit_cnt doubles as the "master ACKed" flag while waiting for the closing fall.
                    ST_RD_ACK: begin
                        sda_low_r <= 1'b0;
                        if (scl_rise_s && (bit_cnt_r == 4'd0)) begin
                            if (sda_smp_s == IIC_ACK) begin
                                o_reg_addr <= o_reg_addr + 8'd1;
                                bit_cnt_r  <= BYTE_BITS;
                            end else begin
                                state_r <= ST_WAIT_STOP;
                            end
                        end else if (scl_fall_s && (bit_cnt_r == BYTE_BITS)) begin
                            state_r   <= ST_RD_DATA;
                            bit_cnt_r <= 4'd0;
                            shift_r   <= i_reg_rdata;
                            sda_low_r <= ~i_reg_rdata[7];
                        end
                    end

                    default: begin
                        state_r   <= ST_IDLE;
                        bit_cnt_r <= 4'd0;
                        sda_low_r <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
